// File: rtl/addr_burst_arbiter_pkg.sv
// Shared types and default field widths for the sample-memory address path.
// The chip field width is also used by the address zero-extender.
package addr_burst_arbiter_pkg;

  localparam int ADDR_EX_W = 19;
  localparam int CHIP_W    = 6;
  localparam int LEN_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/addr_burst_arbiter_rr_pick.sv
// Combinational round-robin first-one finder.
// Scans req upward from ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any_req
);

  int idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        grant   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/addr_burst_arbiter.sv
// Round-robin burst sequencer sharing one {chip, addr} memory port
// among NUM_REQ sampling engines.
module addr_burst_arbiter
  import addr_burst_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int BIT_ADDR_EX = ADDR_EX_W,
  parameter int BIT_CHIP    = CHIP_W,
  parameter int BIT_LEN     = LEN_W
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*BIT_ADDR_EX-1:0]  req_addr,
  input  logic [NUM_REQ*BIT_CHIP-1:0]     req_chip,
  input  logic [NUM_REQ*BIT_LEN-1:0]      req_len,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [NUM_REQ-1:0]              req_done,
  output logic                            mem_valid,
  output logic [BIT_ADDR_EX+BIT_CHIP-1:0] mem_addr,
  input  logic                            mem_ready,
  output logic                            busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int AW    = BIT_ADDR_EX + BIT_CHIP;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       owner;
  logic [PTR_W-1:0]       grant;
  logic                   any_req;
  logic [BIT_ADDR_EX-1:0] cur_addr;
  logic [BIT_CHIP-1:0]    cur_chip;
  logic [BIT_LEN-1:0]     remaining;
  logic                   zl;

  logic [BIT_ADDR_EX-1:0] g_addr;
  logic [BIT_CHIP-1:0]    g_chip;
  logic [BIT_LEN-1:0]     g_len;
  logic [AW-1:0]          nxt;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  assign g_addr = req_addr[grant*BIT_ADDR_EX +: BIT_ADDR_EX];
  assign g_chip = req_chip[grant*BIT_CHIP +: BIT_CHIP];
  assign g_len  = req_len[grant*BIT_LEN +: BIT_LEN];

  // Carry out of the address field rolls into the chip field.
  assign nxt = {cur_chip, cur_addr} + AW'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cur_addr  <= '0;
      cur_chip  <= '0;
      remaining <= '0;
      zl        <= 1'b0;
      req_ack   <= '0;
      req_done  <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
    end else begin
      req_ack  <= '0;
      req_done <= '0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            req_ack[grant] <= 1'b1;
            owner          <= grant;
            cur_addr       <= g_addr;
            cur_chip       <= g_chip;
            remaining      <= g_len;
            busy           <= 1'b1;
            if (g_len == '0) begin
              zl    <= 1'b1;
              state <= DONE;
            end else begin
              zl        <= 1'b0;
              mem_valid <= 1'b1;
              mem_addr  <= {g_chip, g_addr};
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            remaining <= remaining - BIT_LEN'(1);
            if (remaining == BIT_LEN'(1)) begin
              mem_valid       <= 1'b0;
              req_done[owner] <= 1'b1;
              state           <= DONE;
            end else begin
              {cur_chip, cur_addr} <= nxt;
              mem_addr             <= nxt;
            end
          end
        end
        DONE: begin
          // Zero-length grants never passed through ISSUE.
          if (zl) req_done[owner] <= 1'b1;
          zl     <= 1'b0;
          rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0
                                                   : owner + PTR_W'(1);
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
